// File: rtl/fpu8_op_scheduler.sv
// Two-requester round-robin front end for a shared 8-bit minifloat FPU core, one op in flight.
// Optional FPU_SCHED_STATS_EN adds saturating response/exception counters (stat_ops, stat_exc).
module fpu8_op_scheduler #(
    parameter int CORE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [1:0] req0_op,
    input  logic       req0_rnd,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [1:0] req1_op,
    input  logic       req1_rnd,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_is_exc,
    output logic [1:0] rsp_exc_code,
    output logic       fpu_start,
    output logic [7:0] fpu_op_a,
    output logic [7:0] fpu_op_b,
    output logic [1:0] fpu_operation,
    output logic       fpu_round_mode,
    input  logic [7:0] fpu_result,
    input  logic       fpu_is_exc,
    input  logic [1:0] fpu_exc_code,
    output logic       busy
`ifdef FPU_SCHED_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_exc
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] LAT_L = 4'(CORE_LAT);

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] cnt_q, cnt_d;
    logic       start_q, start_d;
    logic [7:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [1:0] op_q, op_d;
    logic       rnd_q, rnd_d;
    logic       id_q, id_d;
    logic [7:0] res_q, res_d;
    logic       exc_q, exc_d;
    logic [1:0] code_q, code_d;

    logic gnt_id;
    logic accept;
    logic rsp_hs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            start_q      <= 1'b0;
            op_a_q       <= 8'd0;
            op_b_q       <= 8'd0;
            op_q         <= 2'd0;
            rnd_q        <= 1'b0;
            id_q         <= 1'b0;
            res_q        <= 8'd0;
            exc_q        <= 1'b0;
            code_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_q         <= op_d;
            rnd_q        <= rnd_d;
            id_q         <= id_d;
            res_q        <= res_d;
            exc_q        <= exc_d;
            code_q       <= code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        start_d      = 1'b0;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_d         = op_q;
        rnd_d        = rnd_q;
        id_d         = id_q;
        res_d        = res_q;
        exc_d        = exc_q;
        code_d       = code_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d       = gnt_id ? req1_a   : req0_a;
                    op_b_d       = gnt_id ? req1_b   : req0_b;
                    op_d         = gnt_id ? req1_op  : req0_op;
                    rnd_d        = gnt_id ? req1_rnd : req0_rnd;
                    id_d         = gnt_id;
                    last_grant_d = gnt_id;
                    cnt_d        = LAT_L;
                    start_d      = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                // Core result is valid in the cycle where the counter reaches 1.
                if (cnt_q == 4'd1) begin
                    res_d   = fpu_result;
                    exc_d   = fpu_is_exc;
                    code_d  = fpu_exc_code;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_id     = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
        req0_ready = rst_n && (state_q == IDLE) && req0_valid && !gnt_id;
        req1_ready = rst_n && (state_q == IDLE) && req1_valid && gnt_id;
        accept     = req0_ready || req1_ready;
        busy       = (state_q != IDLE);
        rsp_valid  = (state_q == RESP);
        rsp_hs     = rsp_valid && rsp_ready;
    end

    assign fpu_start      = start_q;
    assign fpu_op_a       = op_a_q;
    assign fpu_op_b       = op_b_q;
    assign fpu_operation  = op_q;
    assign fpu_round_mode = rnd_q;
    assign rsp_id         = id_q;
    assign rsp_result     = res_q;
    assign rsp_is_exc     = exc_q;
    assign rsp_exc_code   = code_q;

`ifdef FPU_SCHED_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d, stat_exc_q, stat_exc_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_exc_d = stat_exc_q;
        if (rsp_hs) begin
            stat_ops_d = sat_inc(stat_ops_q);
            if (exc_q) stat_exc_d = sat_inc(stat_exc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops_q <= 16'd0;
            stat_exc_q <= 16'd0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_exc_q <= stat_exc_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_exc = stat_exc_q;
`endif

endmodule

// File: tb/tb_fpu8_op_scheduler.sv
// Directed bench for fpu8_op_scheduler; three instances with CORE_LAT = 1, 2, 3 share stimulus.
module tb_fpu8_op_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
    logic [1:0] req0_op = 2'd0, req1_op = 2'd0;
    logic       req0_rnd = 1'b0, req1_rnd = 1'b0;
    logic       rsp_ready = 1'b0;
    logic [7:0] core_res = 8'd0;
    logic       core_exc = 1'b0;
    logic [1:0] core_code = 2'd0;

    logic       req0_ready [3];
    logic       req1_ready [3];
    logic       rsp_valid [3];
    logic       rsp_id [3];
    logic [7:0] rsp_result [3];
    logic       rsp_is_exc [3];
    logic [1:0] rsp_exc_code [3];
    logic       fpu_start [3];
    logic [7:0] fpu_op_a [3];
    logic [7:0] fpu_op_b [3];
    logic [1:0] fpu_operation [3];
    logic       fpu_round_mode [3];
    logic [7:0] fpu_result [3];
    logic       fpu_is_exc [3];
    logic [1:0] fpu_exc_code [3];
    logic       busy [3];
`ifdef FPU_SCHED_STATS_EN
    logic [15:0] stat_ops [3];
    logic [15:0] stat_exc [3];
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        int  since = 100;
        logic core_vld;

        fpu8_op_scheduler #(.CORE_LAT(g + 1)) dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(req0_valid), .req0_ready(req0_ready[g]),
            .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_rnd(req0_rnd),
            .req1_valid(req1_valid), .req1_ready(req1_ready[g]),
            .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_rnd(req1_rnd),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready), .rsp_id(rsp_id[g]),
            .rsp_result(rsp_result[g]), .rsp_is_exc(rsp_is_exc[g]), .rsp_exc_code(rsp_exc_code[g]),
            .fpu_start(fpu_start[g]), .fpu_op_a(fpu_op_a[g]), .fpu_op_b(fpu_op_b[g]),
            .fpu_operation(fpu_operation[g]), .fpu_round_mode(fpu_round_mode[g]),
            .fpu_result(fpu_result[g]), .fpu_is_exc(fpu_is_exc[g]), .fpu_exc_code(fpu_exc_code[g]),
            .busy(busy[g])
`ifdef FPU_SCHED_STATS_EN
            , .stat_ops(stat_ops[g]), .stat_exc(stat_exc[g])
`endif
        );

        // Core model: drives the real result only in cycle CORE_LAT-1 after the start pulse.
        always @(posedge clk) begin
            if (fpu_start[g]) since <= 0;
            else if (since < 1000) since <= since + 1;
        end
        assign core_vld        = fpu_start[g] ? (g == 0) : (since + 1 == g);
        assign fpu_result[g]   = core_vld ? core_res  : 8'hEE;
        assign fpu_is_exc[g]   = core_vld ? core_exc  : 1'b0;
        assign fpu_exc_code[g] = core_vld ? core_code : 2'b00;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        core_res = 8'd0; core_exc = 1'b0; core_code = 2'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        req0_valid = 1'b1;
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cyc();
            #1;
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (rsp_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", k, rsp_valid[k]); end
                n_cmp++; if (fpu_start[k] !== 1'b0) begin n_fail++; $display("FAIL reset_fpu_start[%0d]: got %b want 0", k, fpu_start[k]); end
                n_cmp++; if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
                n_cmp++; if (rsp_result[k] !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_result[%0d]: got %h want 00", k, rsp_result[k]); end
            end
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (req0_ready[k] !== 1'b1) begin n_fail++; $display("FAIL reset_release_req0_ready[%0d]: got %b want 1", k, req0_ready[k]); end
            n_cmp++; if (req1_ready[k] !== 1'b0) begin n_fail++; $display("FAIL reset_release_req1_ready[%0d]: got %b want 0", k, req1_ready[k]); end
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_single();
        idle_inputs();
        do_reset();
        req0_valid = 1'b1; req0_a = 8'h38; req0_b = 8'h38; req0_op = 2'b00; req0_rnd = 1'b0;
        core_res = 8'h40;
        #1;
        n_cmp++; if (req0_ready[0] !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", req0_ready[0]); end
        cyc();
        req0_valid = 1'b0;
        #1;
        n_cmp++; if (fpu_start[0] !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", fpu_start[0]); end
        n_cmp++; if (fpu_op_a[0] !== 8'h38) begin n_fail++; $display("FAIL single_op_a: got %h want 38", fpu_op_a[0]); end
        n_cmp++; if (fpu_op_b[0] !== 8'h38) begin n_fail++; $display("FAIL single_op_b: got %h want 38", fpu_op_b[0]); end
        n_cmp++; if (fpu_operation[0] !== 2'b00) begin n_fail++; $display("FAIL single_op: got %b want 00", fpu_operation[0]); end
        n_cmp++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy[0]); end
        n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", rsp_valid[0]); end
        cyc();
        #1;
        n_cmp++; if (rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid[0]); end
        n_cmp++; if (rsp_id[0] !== 1'b0) begin n_fail++; $display("FAIL single_rsp_id: got %b want 0", rsp_id[0]); end
        n_cmp++; if (rsp_result[0] !== 8'h40) begin n_fail++; $display("FAIL single_rsp_result: got %h want 40", rsp_result[0]); end
        n_cmp++; if (fpu_start[0] !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: got %b want 0", fpu_start[0]); end
        rsp_ready = 1'b1;
        cyc();
        #1;
        n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL single_rsp_clear: got %b want 0", rsp_valid[0]); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", busy[0]); end
    endtask

    task automatic test_contention();
        int ids[$];
        int starts[$];
        int nst;
        idle_inputs();
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_a = 8'h11; req1_a = 8'h22; req0_op = 2'b01; req1_op = 2'b10;
        core_res = 8'h3C;
        do_reset();
        nst = 0;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (fpu_start[1] === 1'b1) begin
                starts.push_back(c);
                n_cmp++; if (fpu_op_a[1] !== ((nst % 2 == 0) ? 8'h11 : 8'h22)) begin n_fail++; $display("FAIL contention_op_a[%0d]: got %h want %h", nst, fpu_op_a[1], (nst % 2 == 0) ? 8'h11 : 8'h22); end
                nst++;
            end
            if (rsp_valid[1] === 1'b1) begin
                ids.push_back(int'(rsp_id[1]));
                n_cmp++; if (rsp_result[1] !== 8'h3C) begin n_fail++; $display("FAIL contention_result: got %h want 3c", rsp_result[1]); end
            end
            cyc();
        end
        n_cmp++; if (ids.size() < 4 || starts.size() < 4) begin n_fail++; $display("FAIL contention_count: got ids=%0d starts=%0d want >=4", ids.size(), starts.size()); end
        for (int i = 0; i < 4 && i < ids.size(); i++) begin
            n_cmp++; if (ids[i] != i % 2) begin n_fail++; $display("FAIL contention_grant[%0d]: got %0d want %0d", i, ids[i], i % 2); end
        end
        for (int i = 1; i < 4 && i < starts.size(); i++) begin
            n_cmp++; if (starts[i] - starts[i-1] != 4) begin n_fail++; $display("FAIL contention_spacing[%0d]: got %0d want 4", i, starts[i] - starts[i-1]); end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        do_reset();
        req0_valid = 1'b1; req0_a = 8'h55; core_res = 8'h12;
        cyc();
        req0_valid = 1'b1; req1_valid = 1'b1;
        cyc();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", c, rsp_valid[0]); end
            n_cmp++; if (rsp_result[0] !== 8'h12) begin n_fail++; $display("FAIL bp_result[%0d]: got %h want 12", c, rsp_result[0]); end
            n_cmp++; if (rsp_id[0] !== 1'b0) begin n_fail++; $display("FAIL bp_id[%0d]: got %b want 0", c, rsp_id[0]); end
            n_cmp++; if (req0_ready[0] !== 1'b0 || req1_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b%b want 00", c, req0_ready[0], req1_ready[0]); end
            n_cmp++; if (fpu_start[0] !== 1'b0) begin n_fail++; $display("FAIL bp_start[%0d]: got %b want 0", c, fpu_start[0]); end
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_hs_valid: got %b want 1", rsp_valid[0]); end
        cyc();
        #1;
        n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_return_idle: got %b want 0", busy[0]); end
        n_cmp++; if (req1_ready[0] !== 1'b1 || req0_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_rr_grant: got r0=%b r1=%b want r0=0 r1=1", req0_ready[0], req1_ready[0]); end
        idle_inputs();
    endtask

    task automatic test_exception();
        idle_inputs();
        do_reset();
        core_res = 8'h7F; core_exc = 1'b1; core_code = 2'b10;
        req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02; req1_op = 2'b11; req1_rnd = 1'b1;
        cyc();
        req1_valid = 1'b0;
        #1;
        n_cmp++; if (fpu_operation[0] !== 2'b11 || fpu_round_mode[0] !== 1'b1) begin n_fail++; $display("FAIL exc_passthru: got op=%b rnd=%b want op=11 rnd=1", fpu_operation[0], fpu_round_mode[0]); end
        cyc();
        #1;
        n_cmp++; if (rsp_is_exc[0] !== 1'b1) begin n_fail++; $display("FAIL exc_flag: got %b want 1", rsp_is_exc[0]); end
        n_cmp++; if (rsp_exc_code[0] !== 2'b10) begin n_fail++; $display("FAIL exc_code: got %b want 10", rsp_exc_code[0]); end
        n_cmp++; if (rsp_result[0] !== 8'h7F) begin n_fail++; $display("FAIL exc_result: got %h want 7f", rsp_result[0]); end
        n_cmp++; if (rsp_id[0] !== 1'b1) begin n_fail++; $display("FAIL exc_id: got %b want 1", rsp_id[0]); end
`ifdef FPU_SCHED_STATS_EN
        n_cmp++; if (stat_ops[0] !== 16'd0) begin n_fail++; $display("FAIL stat_ops_pre: got %0d want 0", stat_ops[0]); end
`endif
        rsp_ready = 1'b1;
        cyc();
        #1;
`ifdef FPU_SCHED_STATS_EN
        n_cmp++; if (stat_ops[0] !== 16'd1) begin n_fail++; $display("FAIL stat_ops: got %0d want 1", stat_ops[0]); end
        n_cmp++; if (stat_exc[0] !== 16'd1) begin n_fail++; $display("FAIL stat_exc: got %0d want 1", stat_exc[0]); end
`endif
        n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL exc_rsp_clear: got %b want 0", rsp_valid[0]); end
        idle_inputs();
    endtask

    task automatic test_abort();
        bit got;
        idle_inputs();
        do_reset();
        req0_valid = 1'b1; req0_a = 8'h44; core_res = 8'hA5;
        cyc();
        req0_valid = 1'b0;
        #1;
        n_cmp++; if (fpu_start[2] !== 1'b1) begin n_fail++; $display("FAIL abort_start: got %b want 1", fpu_start[2]); end
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (busy[2] !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", busy[2]); end
        n_cmp++; if (rsp_result[2] !== 8'h00) begin n_fail++; $display("FAIL abort_rsp_cleared: got %h want 00", rsp_result[2]); end
        for (int c = 0; c < 6; c++) begin
            cyc();
            #1;
            n_cmp++; if (rsp_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp[%0d]: got valid=%b busy=%b want 0 0", c, rsp_valid[2], busy[2]); end
        end
        core_res = 8'h5A;
        req1_valid = 1'b1; req1_a = 8'h99;
        #1;
        n_cmp++; if (req1_ready[2] !== 1'b1) begin n_fail++; $display("FAIL abort_req1_ready: got %b want 1", req1_ready[2]); end
        cyc();
        req1_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (rsp_valid[2] === 1'b1) got = 1'b1;
            else cyc();
        end
        n_cmp++; if (!got) begin n_fail++; $display("FAIL abort_followup_timeout: got no rsp_valid want rsp_valid within 10 cycles"); end
        n_cmp++; if (rsp_id[2] !== 1'b1 || rsp_result[2] !== 8'h5A) begin n_fail++; $display("FAIL abort_followup_rsp: got id=%b res=%h want id=1 res=5a", rsp_id[2], rsp_result[2]); end
        n_cmp++; if (fpu_op_a[2] !== 8'h99) begin n_fail++; $display("FAIL abort_followup_op_a: got %h want 99", fpu_op_a[2]); end
        rsp_ready = 1'b1;
        cyc();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_exception();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu8_op_scheduler.md
Name: fpu8_op_scheduler

Overview:
- Sequences and shares one 8-bit minifloat FPU core between two requesters.
- Round-robin arbitration, operand latching, one-cycle start pulse, wait for core latency, result/exception capture, valid/ready response.
- Sits between client logic (e.g. instruction issue, DMA-fed math engine) and the FPU core. Exactly one operation in flight at a time.

Parameters:
- CORE_LAT, default 1: cycles from start pulse to valid core result; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a, req0_b  in  8  requester 0 operands
- req0_op  in  2  requester 0 operation code
- req0_rnd  in  1  requester 0 round mode
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_rnd: same as requester 0
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester index of response
- rsp_result  out  8  captured core result
- rsp_is_exc  out  1  captured exception flag
- rsp_exc_code  out  2  captured exception code
- fpu_start  out  1  start pulse to core
- fpu_op_a, fpu_op_b  out  8  core operands
- fpu_operation  out  2  core op code
- fpu_round_mode  out  1  core round mode
- fpu_result  in  8  core result
- fpu_is_exc  in  1  core exception flag
- fpu_exc_code  in  2  core exception code
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, last_grant=1 (so requester 0 wins first), wait counter=0. All outputs 0.
- Reset asserted mid-operation aborts the operation. No response is produced, and the captured response is cleared.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational. Only the granted requester's ready is high, and only while its valid is high.
  - Grant rule: if only one valid, grant it. If both valid, grant the requester that is not last_grant.
  - Handshake at edge T (valid&ready): latch a/b/op/rnd into fpu_op_* registers, record grant id, update last_grant, load counter=CORE_LAT, go to EXEC.
- EXEC:
  - fpu_start is high only in the first EXEC cycle (T+1).
  - fpu_op_* stay stable throughout EXEC and RESP.
  - Counter decrements each cycle. On the cycle counter==1, sample fpu_result/fpu_is_exc/fpu_exc_code into the rsp_* registers and go to RESP.
  - With CORE_LAT=1: start and capture both occur in cycle T+1, and rsp_valid is high from T+2.
- RESP:
  - rsp_valid=1. rsp_id, rsp_result, rsp_is_exc and rsp_exc_code stay constant until rsp_ready is sampled high.
  - On the handshake edge: clear rsp_valid and go to IDLE.
  - A new request can be accepted in the first IDLE cycle after that.
- Throughput: one op per CORE_LAT+2 cycles when rsp_ready is held high.
- Both req*_ready are 0 outside IDLE. rsp_ready is ignored outside RESP.
- Requests are never dropped. A requester's valid held high is eventually granted, with at most one op from the other requester in between.
- Operation codes and operands pass through unmodified. Exception classification belongs to the core; the scheduler only forwards it.

Optional Feature:
- FPU_SCHED_STATS_EN defined: adds outputs stat_ops (16 bits) and stat_exc (16 bits).
  - stat_ops increments on each response handshake.
  - stat_exc increments on each response handshake with rsp_is_exc=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Not defined: these ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req0_valid=1 -> during reset: rsp_valid=0, fpu_start=0, busy=0. First cycle after release: req0_ready=1.
- Single op, CORE_LAT=1, core model returns 8'h40 (no exception): req0 a=8'h38, b=8'h38, op=2'b00 accepted at T -> fpu_start=1 with fpu_op_a=8'h38 at T+1; rsp_valid=1, rsp_id=0, rsp_result=8'h40 at T+2.
- Contention: both valid continuously from reset with rsp_ready=1 -> grant order 0,1,0,1. fpu_start pulses exactly 4 cycles apart with CORE_LAT=2.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both req*_ready=0, no fpu_start. After rsp_ready=1, return to IDLE on the next cycle.
- Exception forward: core returns fpu_is_exc=1, fpu_exc_code=2'b10, fpu_result=8'h7F -> rsp_is_exc=1, rsp_exc_code=2'b10, rsp_result=8'h7F. With FPU_SCHED_STATS_EN defined: stat_exc=1, stat_ops=1.
- Abort: CORE_LAT=3, pull rst_n low in the second EXEC cycle -> no rsp_valid ever appears for that op, state=IDLE. A subsequent req1 op completes normally.
